// File: rtl/dts_frame_sync_if.sv
// DTS deframer bus: raw GT word in, payload, flags and bitslip request out.
// The consumer side (deframer) uses the slave modport.
interface dts_frame_sync_if #(
  parameter int INPUT_DWIDTH  = 160,
  parameter int OUTPUT_DWIDTH = 128
);
  logic [INPUT_DWIDTH-1:0]  din;
  logic                     bitslip;
  logic [OUTPUT_DWIDTH-1:0] dout;
  logic                     dout_locked;
  logic                     dout_one_sec;
  logic                     dout_ten_sec;
  logic                     dout_index;
  logic                     dout_sync;
  logic [15:0]              error_count;

  modport master (
    output din,
    input  bitslip, dout, dout_locked,
    input  dout_one_sec, dout_ten_sec,
    input  dout_index, dout_sync,
    input  error_count
  );

  modport slave (
    input  din,
    output bitslip, dout, dout_locked,
    output dout_one_sec, dout_ten_sec,
    output dout_index, dout_sync,
    output error_count
  );
endinterface

// File: rtl/dts_frame_sync.sv
// Per-input DTS deframer: header/index check, lock FSM with flywheel,
// bitslip hunting, and payload/flag output for dts_reorder.
module dts_frame_sync #(
  parameter int         INPUT_DWIDTH     = 160,
  parameter int         OUTPUT_DWIDTH    = 128,
  parameter int         FRAME_LEN        = 4,
  parameter logic [7:0] MARKER           = 8'hBC,
  parameter int         LOCK_COUNT       = 8,
  parameter int         UNLOCK_COUNT     = 4,
  parameter int         HUNT_TIMEOUT     = 16,
  parameter int         SLIP_WAIT_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  dts_frame_sync_if.slave bus
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int HW = $clog2(HUNT_TIMEOUT + 1);
  localparam int SW = $clog2(SLIP_WAIT_CYCLES + 1);
  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    HUNT, SLIP_WAIT, CHECK, LOCKED
  } state_t;

  logic [31:0] hdr_in;
  logic        good_d;
  wire         unused_hdr = ^hdr_in[12:0];

  assign hdr_in = bus.din[INPUT_DWIDTH-1 -: 32];
  assign good_d = (hdr_in[31:24] == MARKER)
               && (hdr_in[23:16] <= LAST);

  logic [OUTPUT_DWIDTH-1:0] pay_q;
  logic [7:0]               idx_q;
  logic [2:0]               flg_q;
  logic                     good_q;
  logic                     v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pay_q  <= '0;
      idx_q  <= '0;
      flg_q  <= '0;
      good_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      pay_q  <= bus.din[OUTPUT_DWIDTH-1:0];
      idx_q  <= hdr_in[23:16];
      flg_q  <= hdr_in[15:13];
      good_q <= good_d;
      v_q    <= 1'b1;
    end
  end

  state_t      state;
  logic [7:0]  exp_q;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_cnt;
  logic [HW-1:0] hunt_cnt;
  logic [SW-1:0] wait_cnt;

  logic       seq_ok;
  logic [7:0] idx_nxt;
  logic [7:0] exp_fw;

  assign seq_ok  = good_q && (idx_q == exp_q);
  assign idx_nxt = (idx_q == LAST) ? 8'd0 : idx_q + 8'd1;
  assign exp_fw  = (exp_q == LAST) ? 8'd0 : exp_q + 8'd1;

  // Outputs default to zero each cycle; only a clean locked word
  // drives payload and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= HUNT;
      exp_q            <= '0;
      good_cnt         <= '0;
      bad_cnt          <= '0;
      hunt_cnt         <= '0;
      wait_cnt         <= '0;
      bus.bitslip      <= 1'b0;
      bus.dout         <= '0;
      bus.dout_locked  <= 1'b0;
      bus.dout_one_sec <= 1'b0;
      bus.dout_ten_sec <= 1'b0;
      bus.dout_index   <= 1'b0;
      bus.dout_sync    <= 1'b0;
      bus.error_count  <= '0;
    end else begin
      bus.bitslip      <= 1'b0;
      bus.dout         <= '0;
      bus.dout_locked  <= 1'b0;
      bus.dout_one_sec <= 1'b0;
      bus.dout_ten_sec <= 1'b0;
      bus.dout_index   <= 1'b0;
      bus.dout_sync    <= 1'b0;
      if (v_q) begin
        unique case (state)
          HUNT: begin
            if (good_q) begin
              state    <= CHECK;
              exp_q    <= idx_nxt;
              good_cnt <= GW'(1);
              hunt_cnt <= '0;
            end else if (hunt_cnt == HW'(HUNT_TIMEOUT - 1)) begin
              state       <= SLIP_WAIT;
              bus.bitslip <= 1'b1;
              hunt_cnt    <= '0;
              wait_cnt    <= '0;
            end else begin
              hunt_cnt <= hunt_cnt + 1'b1;
            end
          end
          SLIP_WAIT: begin
            if (wait_cnt == SW'(SLIP_WAIT_CYCLES - 1)) begin
              state    <= HUNT;
              wait_cnt <= '0;
              hunt_cnt <= '0;
              good_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          CHECK: begin
            if (seq_ok) begin
              exp_q <= idx_nxt;
              if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                state            <= LOCKED;
                good_cnt         <= '0;
                bad_cnt          <= '0;
                bus.dout_locked  <= 1'b1;
                bus.dout         <= pay_q;
                bus.dout_one_sec <= flg_q[2];
                bus.dout_ten_sec <= flg_q[1];
                bus.dout_index   <= flg_q[0];
                bus.dout_sync    <= (idx_q == 8'd0);
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else begin
              state    <= HUNT;
              good_cnt <= '0;
              hunt_cnt <= '0;
            end
          end
          LOCKED: begin
            exp_q <= exp_fw;
            if (seq_ok) begin
              bad_cnt          <= '0;
              bus.dout_locked  <= 1'b1;
              bus.dout         <= pay_q;
              bus.dout_one_sec <= flg_q[2];
              bus.dout_ten_sec <= flg_q[1];
              bus.dout_index   <= flg_q[0];
              bus.dout_sync    <= (idx_q == 8'd0);
            end else begin
              if (bus.error_count != 16'hFFFF)
                bus.error_count <= bus.error_count + 1'b1;
              if (bad_cnt == BW'(UNLOCK_COUNT - 1)) begin
                state    <= HUNT;
                bad_cnt  <= '0;
                hunt_cnt <= '0;
                good_cnt <= '0;
              end else begin
                bad_cnt         <= bad_cnt + 1'b1;
                bus.dout_locked <= 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dts_frame_sync.sv
// Directed + random bench for dts_frame_sync against a word-level
// reference model; a second instance covers error_count saturation.
module tb_dts_frame_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dts_frame_sync_if ifc ();
  dts_frame_sync_if ifc2 ();

  dts_frame_sync dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  dts_frame_sync #(
    .UNLOCK_COUNT (1 << 17)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (ifc2.slave)
  );

  wire [149:0] obs = {
    ifc.bitslip, ifc.dout, ifc.dout_locked,
    ifc.dout_one_sec, ifc.dout_ten_sec,
    ifc.dout_index, ifc.dout_sync,
    ifc.error_count
  };

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [149:0] q[$];

  int m_hold, m_run, m_bad, m_hunt, m_err, m_exp;
  bit m_lock;

  function automatic void model_reset();
    m_hold = 0; m_run = 0; m_bad = 0;
    m_hunt = 0; m_err = 0; m_exp = 0;
    m_lock = 0;
  endfunction

  // Word-level behaviour: returns the expected output bundle
  // produced for word w.
  function automatic logic [149:0] model(input logic [159:0] w);
    int idx;
    bit good, ok, slip, lk, emit;
    logic [127:0] d;
    logic [3:0] fl;
    idx  = int'(w[151:144]);
    good = (w[159:152] == 8'hBC) && (idx < 4);
    ok   = good && (idx == m_exp);
    slip = 0; lk = 0; emit = 0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (m_lock) begin
      m_exp = (m_exp + 1) % 4;
      if (ok) begin
        m_bad = 0; lk = 1; emit = 1;
      end else begin
        m_bad++;
        if (m_err < 65535) m_err++;
        if (m_bad == 4) begin
          m_lock = 0; m_bad = 0; m_run = 0; m_hunt = 0;
        end else lk = 1;
      end
    end else if (m_run > 0) begin
      if (ok) begin
        m_run++;
        m_exp = (idx + 1) % 4;
        if (m_run == 8) begin
          m_lock = 1; m_run = 0; m_bad = 0;
          lk = 1; emit = 1;
        end
      end else begin
        m_run = 0; m_hunt = 0;
      end
    end else begin
      if (good) begin
        m_run = 1; m_hunt = 0;
        m_exp = (idx + 1) % 4;
      end else begin
        m_hunt++;
        if (m_hunt == 16) begin
          slip = 1; m_hunt = 0; m_hold = 8;
        end
      end
    end
    d  = emit ? w[127:0] : '0;
    fl = emit ? {w[143:141], idx == 0} : 4'b0;
    return {slip, d, lk, fl, m_err[15:0]};
  endfunction

  function automatic logic [159:0] mk(
    input logic [7:0] m, input logic [7:0] idx,
    input logic [127:0] pl);
    logic [15:0] lo;
    lo = 16'($urandom);
    return {m, idx, lo, pl};
  endfunction

  function automatic logic [127:0] rpl();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [159:0] good_w();
    return mk(8'hBC, 8'(k % 4), rpl());
  endfunction

  function automatic logic [159:0] bad_w();
    logic [7:0] m, idx;
    int r;
    r = $urandom_range(0, 2);
    m = 8'hBC;
    idx = 8'(k % 4);
    if (r == 0) begin
      m = 8'($urandom);
      if (m == 8'hBC) m = 8'h00;
    end else if (r == 1) begin
      idx = 8'($urandom_range(4, 255));
    end else begin
      idx = 8'((k + $urandom_range(1, 3)) % 4);
    end
    return mk(m, idx, rpl());
  endfunction

  task automatic chk(input string tag,
                     input logic [149:0] o,
                     input logic [149:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic step(input logic [159:0] w, input string tag);
    chk(tag, obs, q.pop_front());
    q.push_back(model(w));
    ifc.din = w;
    k++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.din = {5{$urandom}};
    #1;
    chk("rst_async", obs, '0);
    @(negedge clk);
    chk("rst_hold", obs, '0);
    rst = 1'b0;
    model_reset();
    q.delete();
    q.push_back('0);
    q.push_back('0);
    k = 0;
  endtask

  initial begin
    int seqv[6];
    int k2;
    ifc.din  = '0;
    ifc2.din = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // hunt: slip on 16th bad, 8 ignored, slip after 16 more
    do_reset();
    repeat (40) step(mk(8'h00, 8'(k % 4), rpl()), "hunt");
    repeat (2) step(mk(8'h00, 8'(k % 4), rpl()), "hunt");

    // clean acquisition, payload = word number
    do_reset();
    for (int i = 0; i < 20; i++)
      step(mk(8'hBC, 8'(i % 4), 128'(i)), "acq");

    // flywheel: 3 bad then good, later 4 bad unlocks
    repeat (3) step(bad_w(), "fly_bad3");
    repeat (5) step(good_w(), "fly_good");
    repeat (4) step(bad_w(), "fly_bad4");
    repeat (12) step(good_w(), "relock");

    // sequence break inside CHECK
    do_reset();
    seqv = '{0, 1, 2, 3, 0, 2};
    for (int i = 0; i < 6; i++)
      step(mk(8'hBC, 8'(seqv[i]), rpl()), "seq_brk");
    for (int i = 0; i < 12; i++)
      step(mk(8'hBC, 8'((3 + i) % 4), rpl()), "seq_relock");

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) != 0) step(good_w(), "rnd_hi");
      else step(bad_w(), "rnd_hi");
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 6) step(good_w(), "rnd_lo");
      else step(bad_w(), "rnd_lo");
    end

    // reset while the slip pulse is out
    do_reset();
    repeat (17) step(mk(8'h00, 8'd0, rpl()), "pre_slip");
    chk("slip_pulse", obs, q.pop_front());
    chk("slip_seen", {149'b0, ifc.bitslip}, 150'd1);
    do_reset();
    repeat (20) step(good_w(), "post_rst");

    // saturation on the wide-unlock instance
    do_reset();
    k2 = 0;
    for (int i = 0; i < 8; i++) begin
      ifc2.din = mk(8'hBC, 8'(k2 % 4), rpl());
      k2++;
      @(negedge clk);
    end
    for (int n = 0; n < 3; n++) begin
      int nbad;
      logic [15:0] want;
      nbad = (n == 0) ? 10 : (n == 1) ? 65524 : 6;
      want = (n == 0) ? 16'd10
           : (n == 1) ? 16'd65534 : 16'hFFFF;
      repeat (nbad) begin
        ifc2.din = mk(8'h00, 8'(k2 % 4), rpl());
        k2++;
        @(negedge clk);
      end
      repeat (3) begin
        ifc2.din = mk(8'hBC, 8'(k2 % 4), rpl());
        k2++;
        @(negedge clk);
      end
      chk("sat_err",
          {133'b0, ifc2.dout_locked, ifc2.error_count},
          {133'b0, 1'b1, want});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dts_frame_sync.md
Name: dts_frame_sync

Overview:
- Per-input DTS deframer. Sits directly upstream of dts_reorder in the gt_clkout domain.
- Takes the 160-bit parallel words from the GT receiver, verifies the per-word header and word-index sequence, and runs a lock/unlock state machine.
- Requests GT bitslips while hunting for alignment.
- Emits the 128-bit payload plus locked/one_sec/ten_sec/index/sync flags in the form dts_reorder consumes. One instance per input, instantiated as an array.

Parameters:
- INPUT_DWIDTH, 160, GT word width; header is din[159:128].
- OUTPUT_DWIDTH, 128, payload width; din[127:0].
- FRAME_LEN, 4, words per DTS frame; header index runs 0..FRAME_LEN-1.
- MARKER, 8'hBC, constant expected in header[31:24] of every word.
- LOCK_COUNT, 8, consecutive good in-sequence words needed to declare lock.
- UNLOCK_COUNT, 4, consecutive bad words while locked that drop lock.
- HUNT_TIMEOUT, 16, consecutive bad words in HUNT before a bitslip request.
- SLIP_WAIT_CYCLES, 8, cycles ignored after a bitslip while the GT settles.

Ports:
- clk  in  1  gt_clkout; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  160  raw GT word, one per cycle; no valid qualifier.
- bitslip  out  1  one-cycle pulse requesting a one-bit GT slip.
- dout  out  128  payload.
- dout_locked  out  1  high while in LOCKED.
- dout_one_sec  out  1  header[15] passthrough.
- dout_ten_sec  out  1  header[14] passthrough.
- dout_index  out  1  header[13] passthrough.
- dout_sync  out  1  pulse on word with header index 0.
- error_count  out  16  saturating count of bad words seen while LOCKED.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst). rst asserted → all state and outputs to reset values immediately.
- Reset values: state=HUNT; every output 0, including dout and error_count.
- Pipeline: stage 1 registers din and computes good = (hdr[31:24]==MARKER) && (hdr[23:16] < FRAME_LEN). Stage 2 registers outputs. Latency din→dout is 2 cycles.
- In-sequence: hdr index == expected. expected = (prev+1) mod FRAME_LEN; FRAME_LEN-1 wraps to 0.
- HUNT:
  - Good word → expected=idx+1 mod FRAME_LEN, good_cnt=1, go to CHECK.
  - Bad word → hunt_cnt++.
  - hunt_cnt reaches HUNT_TIMEOUT → bitslip=1 for exactly one cycle, hunt_cnt=0, go to SLIP_WAIT.
- SLIP_WAIT: ignore din for SLIP_WAIT_CYCLES cycles, then go to HUNT with counters cleared. No second bitslip is possible inside this window.
- CHECK:
  - Good and in-sequence → good_cnt++, expected advances.
  - good_cnt reaches LOCK_COUNT → LOCKED, bad_cnt=0.
  - Any bad or out-of-sequence word → HUNT, good_cnt=0. That word is not re-evaluated as a HUNT candidate.
- LOCKED (flywheel):
  - expected advances every cycle regardless of word quality.
  - Good and in-sequence → bad_cnt=0.
  - Otherwise → bad_cnt++ and error_count++ (saturates at 16'hFFFF, never wraps).
  - bad_cnt reaching UNLOCK_COUNT → HUNT; dout_locked falls on the same output cycle.
  - An isolated bad word followed by a good one resets bad_cnt.
- Outputs while LOCKED:
  - Good word → dout=payload; flags from header; dout_sync = (idx==0).
  - Bad word → dout=0, all flags 0, dout_locked stays 1.
- Outputs outside LOCKED: dout and all flags forced to 0.
- error_count persists through unlock/relock and clears only on rst.
- Reset mid-frame or mid-SLIP_WAIT: aborts cleanly to HUNT; any bitslip pulse in flight is cancelled.

Test Plan:
- Reset: assert rst with garbage din → all outputs 0 within the same cycle. After release, no bitslip for the first 15 bad words.
- Clean acquisition: continuous valid frames (marker BC, idx 0,1,2,3,…; payload = word number) starting from reset → dout_locked rises 2 cycles after the 8th good word. dout then carries the payloads; dout_sync pulses every 4th cycle on idx 0.
- Hunt/slip: 16 words with marker 8'h00 → exactly one bitslip pulse on the 16th. Next 8 cycles are ignored even if bad; a second pulse only after a further 16 bad words.
- Sequence break in CHECK: 5 good words then idx skip (0,1,2,3,0,2) → returns to HUNT, dout_locked stays 0, relocks after 8 more good words.
- Flywheel: while locked, inject 3 bad words then good → lock held, dout=0 for 3 cycles, error_count=3. Then inject 4 consecutive bad → dout_locked falls, error_count=7.
- Saturation: force 70000 bad-but-locked events (relock between bursts) → error_count holds 16'hFFFF.
